// File: rtl/ltc2195_lane_tx_if.sv
// Word-pair handshake and serial lane outputs of the LTC2195 2-lane transmitter.
// The source side (master) offers word pairs and observes the lanes; the transmitter is the slave.
interface ltc2195_lane_tx_if;
  logic [15:0] ADC0_in;
  logic [15:0] ADC1_in;
  logic        valid_in;
  logic        ready_out;
  logic        pattern_en_in;
  logic [1:0]  D0_out;
  logic [1:0]  D1_out;
  logic        FR_out;
  logic        DCO_out;
  logic        underflow_out;
  logic [15:0] frame_cnt_out;

  modport master (
    output ADC0_in, ADC1_in, valid_in, pattern_en_in,
    input  ready_out, D0_out, D1_out, FR_out, DCO_out, underflow_out, frame_cnt_out
  );

  modport slave (
    input  ADC0_in, ADC1_in, valid_in, pattern_en_in,
    output ready_out, D0_out, D1_out, FR_out, DCO_out, underflow_out, frame_cnt_out
  );
endinterface

// File: rtl/ltc2195_lane_tx.sv
// LTC2195 2-lane/16-bit SDR transmitter: one holding pair, 8-cycle frames, FR/DCO generation.
//   state | meaning
//   IDLE  | lanes, FR, DCO low; waits for the first held pair
//   RUN   | bit_cnt 0..7 free-running; next frame loaded at bit_cnt=7
module ltc2195_lane_tx #(
  parameter logic [15:0] TEST_PATTERN = 16'hA5C3
) (
  input logic              clk_in,
  input logic              rst_in,
  ltc2195_lane_tx_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] hold0_q, hold0_d, hold1_q, hold1_d;
  logic [15:0] word0_q, word0_d, word1_q, word1_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  d0_q, d0_d, d1_q, d1_d;
  logic        fr_q, fr_d, dco_q, dco_d, uf_q, uf_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        accept, load, from_hold, running;
  logic [3:0]  sel;

  // Gated by rst_in so the source sees "not ready" for the whole reset window.
  assign bus.ready_out = ~hold_full_q & ~rst_in;
  assign accept        = bus.valid_in & bus.ready_out;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word0_d     = word0_q;
    word1_d     = word1_q;
    frame_cnt_d = frame_cnt_q;
    uf_d        = 1'b0;
    from_hold   = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE:    load = hold_full_q;
      RUN:     load = (bit_cnt_q == 3'd7);
      default: load = 1'b0;
    endcase

    if (state_q == RUN) bit_cnt_d = bit_cnt_q + 3'd1;

    if (load) begin
      state_d     = RUN;
      bit_cnt_d   = 3'd0;
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (bus.pattern_en_in) begin
        word0_d = TEST_PATTERN;
        word1_d = TEST_PATTERN;
      end else if (hold_full_q) begin
        word0_d   = hold0_q;
        word1_d   = hold1_q;
        from_hold = 1'b1;
      end else begin
        uf_d = 1'b1;
      end
    end

    // Accept wins over the clear so a pair arriving with a load is never lost.
    hold_full_d = accept ? 1'b1 : (from_hold ? 1'b0 : hold_full_q);
    hold0_d     = accept ? bus.ADC0_in : hold0_q;
    hold1_d     = accept ? bus.ADC1_in : hold1_q;

    running = (state_d == RUN);
    sel     = 4'd14 - {bit_cnt_d, 1'b0};
    d0_d    = running ? word0_d[sel +: 2] : 2'b00;
    d1_d    = running ? word1_d[sel +: 2] : 2'b00;
    fr_d    = running & ~bit_cnt_d[2];
    dco_d   = running & ~bit_cnt_d[0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold0_q     <= '0;
      hold1_q     <= '0;
      word0_q     <= '0;
      word1_q     <= '0;
      bit_cnt_q   <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      fr_q        <= 1'b0;
      dco_q       <= 1'b0;
      uf_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      word0_q     <= word0_d;
      word1_q     <= word1_d;
      bit_cnt_q   <= bit_cnt_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      fr_q        <= fr_d;
      dco_q       <= dco_d;
      uf_q        <= uf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.D0_out        = d0_q;
  assign bus.D1_out        = d1_q;
  assign bus.FR_out        = fr_q;
  assign bus.DCO_out       = dco_q;
  assign bus.underflow_out = uf_q;
  assign bus.frame_cnt_out = frame_cnt_q;

endmodule

// File: tb/tb_ltc2195_lane_tx.sv
// Directed bench for ltc2195_lane_tx: frame serialization, underflow repeat, test pattern,
// back-to-back streaming and mid-frame reset, all against hand-computed values.
module tb_ltc2195_lane_tx;

  logic clk_in = 1'b0;
  logic rst_in;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  ltc2195_lane_tx_if bus ();

  ltc2195_lane_tx dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Starts at a bit_cnt=0 cycle, gathers 8 cycles of lane data, ends at the next bit_cnt=0 cycle.
  task automatic get_frame(output logic [15:0] w0, output logic [15:0] w1,
                           output logic [7:0] fr, output logic [7:0] dco,
                           output logic uf0, output logic [15:0] fc0, output int rdy);
    w0 = '0; w1 = '0; fr = '0; dco = '0; rdy = 0;
    uf0 = bus.underflow_out;
    fc0 = bus.frame_cnt_out;
    for (int k = 0; k < 8; k++) begin
      w0  = {w0[13:0], bus.D0_out};
      w1  = {w1[13:0], bus.D1_out};
      fr  = {fr[6:0], bus.FR_out};
      dco = {dco[6:0], bus.DCO_out};
      if (bus.ready_out) rdy++;
      step();
    end
  endtask

  logic [15:0] w0, w1, fc;
  logic [7:0]  fr, dco;
  logic        uf;
  int          rdy;

  initial begin
    rst_in = 1'b1;
    bus.ADC0_in = '0;
    bus.ADC1_in = '0;
    bus.valid_in = 1'b0;
    bus.pattern_en_in = 1'b0;
    step();
    step();
    check_eq("rst_ready", bus.ready_out, 1'b0);
    check_eq("rst_d0", bus.D0_out, 2'b00);
    check_eq("rst_fr", bus.FR_out, 1'b0);
    check_eq("rst_dco", bus.DCO_out, 1'b0);
    check_eq("rst_fcnt", bus.frame_cnt_out, 16'd0);
    rst_in = 1'b0;
    #1;
    check_eq("rel_ready", bus.ready_out, 1'b1);

    // Single pair B38F / 0000
    bus.ADC0_in = 16'hB38F;
    bus.ADC1_in = 16'h0000;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    check_eq("t1_ready_full", bus.ready_out, 1'b0);
    check_eq("t1_idle_fr", bus.FR_out, 1'b0);
    step();
    check_eq("t1_bit0_d0", bus.D0_out, 2'b10);
    get_frame(w0, w1, fr, dco, uf, fc, rdy);
    check_eq("t1_w0", w0, 16'hB38F);
    check_eq("t1_w1", w1, 16'h0000);
    check_eq("t1_fr", fr, 8'b1111_0000);
    check_eq("t1_dco", dco, 8'b1010_1010);
    check_eq("t1_uf", uf, 1'b0);
    check_eq("t1_fcnt", fc, 16'd1);

    // No new word: repeat with underflow
    get_frame(w0, w1, fr, dco, uf, fc, rdy);
    check_eq("t3_w0_rep", w0, 16'hB38F);
    check_eq("t3_uf2", uf, 1'b1);
    check_eq("t3_fcnt2", fc, 16'd2);
    check_eq("t3_uf3", bus.underflow_out, 1'b1);
    check_eq("t3_fcnt3", bus.frame_cnt_out, 16'd3);

    // Pair 1234/5678 held while the test pattern is selected at the load
    bus.ADC0_in = 16'h1234;
    bus.ADC1_in = 16'h5678;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    check_eq("t3_uf_mid", bus.underflow_out, 1'b0);
    for (int i = 0; i < 6; i++) step();
    bus.pattern_en_in = 1'b1;
    step();
    bus.pattern_en_in = 1'b0;
    get_frame(w0, w1, fr, dco, uf, fc, rdy);
    check_eq("t4_pat_w0", w0, 16'hA5C3);
    check_eq("t4_pat_w1", w1, 16'hA5C3);
    check_eq("t4_pat_uf", uf, 1'b0);
    check_eq("t4_pat_fcnt", fc, 16'd4);
    check_eq("t4_pat_rdy", rdy, 0);
    get_frame(w0, w1, fr, dco, uf, fc, rdy);
    check_eq("t4_held_w0", w0, 16'h1234);
    check_eq("t4_held_w1", w1, 16'h5678);
    check_eq("t4_held_uf", uf, 1'b0);
    check_eq("t4_held_rdy", rdy, 8);

    // Streaming: valid held high with incrementing pairs
    fork
      begin
        int  seq;
        logic r;
        seq = 1;
        for (int c = 0; c < 40; c++) begin
          bus.ADC0_in  = 16'h1000 + 16'(seq);
          bus.ADC1_in  = 16'h2000 + 16'(seq);
          bus.valid_in = 1'b1;
          r = bus.ready_out;
          step();
          if (r) seq++;
        end
      end
      begin
        get_frame(w0, w1, fr, dco, uf, fc, rdy);
        check_eq("t2_rep_w0", w0, 16'h1234);
        check_eq("t2_rep_uf", uf, 1'b1);
        check_eq("t2_rep_fcnt", fc, 16'd6);
        check_eq("t2_rep_rdy", rdy, 1);
        for (int f = 1; f <= 4; f++) begin
          get_frame(w0, w1, fr, dco, uf, fc, rdy);
          check_eq("t2_w0", w0, 16'h1000 + 16'(f));
          check_eq("t2_w1", w1, 16'h2000 + 16'(f));
          check_eq("t2_uf", uf, 1'b0);
          check_eq("t2_fcnt", fc, 16'(6 + f));
          check_eq("t2_rdy", rdy, 1);
        end
      end
    join
    bus.valid_in = 1'b0;
    check_eq("t2_last_d0", bus.D0_out, 2'b00);
    check_eq("t2_last_fcnt", bus.frame_cnt_out, 16'd11);

    // Reset at bit_cnt=3
    step();
    step();
    step();
    check_eq("t5_fr_b3", bus.FR_out, 1'b1);
    check_eq("t5_dco_b3", bus.DCO_out, 1'b0);
    rst_in = 1'b1;
    #1;
    check_eq("t5_ready_rst", bus.ready_out, 1'b0);
    step();
    check_eq("t5_d0", bus.D0_out, 2'b00);
    check_eq("t5_fr", bus.FR_out, 1'b0);
    check_eq("t5_dco", bus.DCO_out, 1'b0);
    check_eq("t5_fcnt", bus.frame_cnt_out, 16'd0);
    check_eq("t5_ready", bus.ready_out, 1'b0);
    rst_in = 1'b0;
    bus.pattern_en_in = 1'b1;
    #1;
    check_eq("t5_ready_rel", bus.ready_out, 1'b1);
    step();
    step();
    step();
    check_eq("t5_idle_fr", bus.FR_out, 1'b0);
    check_eq("t5_idle_dco", bus.DCO_out, 1'b0);
    check_eq("t5_idle_fcnt", bus.frame_cnt_out, 16'd0);
    bus.pattern_en_in = 1'b0;
    bus.ADC0_in = 16'h00FF;
    bus.ADC1_in = 16'hFF00;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    step();
    get_frame(w0, w1, fr, dco, uf, fc, rdy);
    check_eq("t5_new_w0", w0, 16'h00FF);
    check_eq("t5_new_w1", w1, 16'hFF00);
    check_eq("t5_new_fcnt", fc, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
